// File: rtl/neuron_core_sequencer.sv
// Event/fire sequencer for a neuron core: integrates axon events into per-neuron potentials
// and streams spiking neuron indices on a fire sweep. Optional macro SPIKE_COUNT_EN adds spike_count_o.
module neuron_core_sequencer #(
   parameter int                 NUM_NEURONS     = 256,
   parameter int                 IDX_W           = 8,
   parameter logic signed [7:0]  RESET_POTENTIAL = 8'sd0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    axon_valid_i,
   output logic                    axon_ready_o,
   input  logic [IDX_W-1:0]        axon_idx_i,
   input  logic [1:0]              axon_type_i,
   input  logic                    picture_done_i,
   output logic                    syn_rd_en_o,
   output logic [IDX_W-1:0]        syn_addr_o,
   input  logic [NUM_NEURONS-1:0]  syn_row_i,
   output logic [7:0]              nb_potential_o,
   output logic                    nb_enable_o,
   output logic [1:0]              nb_weight_sel_o,
   output logic                    nb_picture_done_o,
   input  logic [7:0]              nb_new_potential_i,
   input  logic                    nb_spike_i,
   output logic                    spike_valid_o,
   input  logic                    spike_ready_i,
   output logic [IDX_W-1:0]        spike_idx_o,
   output logic                    busy_o,
   output logic                    done_o
`ifdef SPIKE_COUNT_EN
   ,
   output logic [15:0]             spike_count_o
`endif
);

   localparam int               AW       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_INTEG = 3'd2,
      S_FIRE  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [7:0]              r_pot [NUM_NEURONS];
   logic [NUM_NEURONS-1:0]  r_row;
   logic [1:0]              r_type;
   logic [IDX_W-1:0]        r_j;
   logic [IDX_W-1:0]        w_j_nxt;
   logic                    r_pend;
   logic                    w_pend_nxt;
   logic [AW-1:0]           w_jsel;
   logic                    w_last;
   logic                    w_pot_we;
   logic                    w_row_load;
   logic                    w_type_load;

   assign w_jsel = r_j[AW-1:0];
   assign w_last = (r_j == LAST_IDX);

   // State, neuron counter, pending-picture flag and latched event context
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_j     <= '0;
         r_pend  <= 1'b0;
         r_row   <= '0;
         r_type  <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_j     <= w_j_nxt;
         r_pend  <= w_pend_nxt;
         if (w_row_load) begin
            r_row <= syn_row_i;
         end
         if (w_type_load) begin
            r_type <= axon_type_i;
         end
      end
   end

   // Potential store; the datapath result is written back unmodified
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            r_pot[i] <= RESET_POTENTIAL;
         end
      end else if (w_pot_we) begin
         r_pot[w_jsel] <= nb_new_potential_i;
      end
   end

   // Next-state and output decode
   always_comb begin
      w_state_nxt       = r_state;
      w_j_nxt           = r_j;
      w_pend_nxt        = r_pend | picture_done_i;
      w_pot_we          = 1'b0;
      w_row_load        = 1'b0;
      w_type_load       = 1'b0;
      axon_ready_o      = 1'b0;
      syn_rd_en_o       = 1'b0;
      syn_addr_o        = '0;
      nb_potential_o    = 8'd0;
      nb_enable_o       = 1'b0;
      nb_weight_sel_o   = 2'd0;
      nb_picture_done_o = 1'b0;
      spike_valid_o     = 1'b0;
      spike_idx_o       = '0;
      busy_o            = 1'b1;
      done_o            = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy_o       = 1'b0;
            axon_ready_o = ~r_pend;
            if (r_pend) begin
               w_state_nxt = S_FIRE;
               w_j_nxt     = '0;
            end else if (axon_valid_i) begin
               w_type_load = 1'b1;
               syn_rd_en_o = 1'b1;
               syn_addr_o  = axon_idx_i;
               w_state_nxt = S_FETCH;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_FETCH: begin
            w_row_load  = 1'b1;
            w_j_nxt     = '0;
            w_state_nxt = S_INTEG;
         end
         S_INTEG: begin
            nb_potential_o  = r_pot[w_jsel];
            nb_enable_o     = r_row[w_jsel];
            nb_weight_sel_o = r_type;
            w_pot_we        = 1'b1;
            if (w_last) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_j_nxt = r_j + {{(IDX_W-1){1'b0}}, 1'b1};
            end
         end
         S_FIRE: begin
            nb_picture_done_o = 1'b1;
            nb_potential_o    = r_pot[w_jsel];
            spike_valid_o     = nb_spike_i;
            spike_idx_o       = nb_spike_i ? r_j : '0;
            // A pending spike stalls the sweep until the consumer takes it
            if (!nb_spike_i || spike_ready_i) begin
               w_pot_we = 1'b1;
               if (w_last) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_j_nxt = r_j + {{(IDX_W-1){1'b0}}, 1'b1};
               end
            end else begin
               w_state_nxt = S_FIRE;
            end
         end
         S_DONE: begin
            done_o      = 1'b1;
            w_pend_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_pend_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

`ifdef SPIKE_COUNT_EN
   logic [15:0] r_spike_count;

   // Saturating count of accepted spikes, restarted on every fire sweep entry
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_spike_count <= 16'd0;
      end else if ((r_state == S_IDLE) && r_pend) begin
         r_spike_count <= 16'd0;
      end else if (spike_valid_o && spike_ready_i && (r_spike_count != 16'hFFFF)) begin
         r_spike_count <= r_spike_count + 16'd1;
      end
   end

   assign spike_count_o = r_spike_count;
`endif

endmodule

// File: doc/neuron_core_sequencer.md
Name: neuron_core_sequencer

Overview:
- Upstream controller for the per-neuron integrate/fire datapath in the 256x256 neuron core.
- Accepts axon spike events and fetches each event's crossbar connectivity row.
- Sweeps all neurons one per cycle, driving the shared combinational neuron datapath and writing back the potentials it returns.
- On a picture-done request it runs a fire sweep and streams out the indices of spiking neurons.

Parameters:
- NUM_NEURONS, 256, neurons per core (power of two, 2..256).
- IDX_W, 8, width of axon and neuron indices.
- RESET_POTENTIAL, 0, signed 8-bit value loaded into every potential on reset.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset, synchronous, active-high.
- axon_valid_i  in  1  spike event valid.
- axon_ready_o  out  1  event accepted when valid&&ready.
- axon_idx_i  in  IDX_W  axon index of the event.
- axon_type_i  in  2  weight type of the event.
- picture_done_i  in  1  one-cycle request to start the fire sweep.
- syn_rd_en_o  out  1  crossbar row read strobe.
- syn_addr_o  out  IDX_W  crossbar row address.
- syn_row_i  in  NUM_NEURONS  connectivity row; valid the cycle after syn_rd_en_o.
- nb_potential_o  out  8  current potential of the selected neuron.
- nb_enable_o  out  1  synapse bit of the selected neuron.
- nb_weight_sel_o  out  2  weight select.
- nb_picture_done_o  out  1  high during the fire sweep.
- nb_new_potential_i  in  8  datapath result; same-cycle combinational.
- nb_spike_i  in  1  datapath spike; same-cycle combinational.
- spike_valid_o  out  1  output spike valid.
- spike_ready_i  in  1  output spike accepted.
- spike_idx_o  out  IDX_W  index of the spiking neuron.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse at the end of the fire sweep.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset effects:
  - All potentials set to RESET_POTENTIAL; FSM goes to IDLE.
  - Pending-picture flag and neuron counter j cleared.
  - All outputs 0, except axon_ready_o, which is 1 in IDLE after reset.
- Storage: register array pot[NUM_NEURONS] of signed 8 bit. The block only stores values; it performs no arithmetic on them.
- FSM states: IDLE, FETCH, INTEG, FIRE, DONE.
- IDLE:
  - axon_ready_o = !pend.
  - If pend: go to FIRE with j=0.
  - Else if axon_valid_i: latch type, assert syn_rd_en_o with syn_addr_o=axon_idx_i, go to FETCH.
- FETCH: latch syn_row_i into the row register; j=0; go to INTEG.
- INTEG (one neuron per cycle):
  - Drive nb_potential_o=pot[j], nb_enable_o=row[j], nb_weight_sel_o=latched type, nb_picture_done_o=0.
  - Write pot[j] <= nb_new_potential_i.
  - At j=NUM_NEURONS-1, go to IDLE.
  - Event latency: accept cycle T, final write at T+1+NUM_NEURONS, next accept possible at T+2+NUM_NEURONS.
- FIRE:
  - Drive nb_picture_done_o=1 and nb_potential_o=pot[j].
  - If nb_spike_i=0: write pot[j] and advance j.
  - If nb_spike_i=1: spike_valid_o=1, spike_idx_o=j. Write pot[j] and advance only on the cycle spike_ready_i=1; otherwise hold all outputs stable.
  - The last neuron advances to DONE; its spike, if any, must be accepted first.
- DONE: done_o=1 for one cycle; clear pend; go to IDLE.
- Pending picture:
  - picture_done_i in any state sets pend.
  - A picture_done_i arriving during INTEG or FETCH is serviced after the current event completes.
  - A picture_done_i arriving during FIRE or DONE is absorbed; it does not trigger a second sweep.
- Priority: when pend=1, no new events are accepted (axon_ready_o=0) until DONE.
- Simultaneous picture_done_i and axon_valid_i in IDLE with pend=0: the event is accepted this cycle; pend is set and serviced after the event.
- j is IDX_W wide and compares against NUM_NEURONS-1; no wrap beyond the last neuron.
- Reset mid-sweep aborts the sweep: potentials are reinitialised and no done_o pulse is issued.

Optional Feature:
- Macro SPIKE_COUNT_EN.
- Defined:
  - Adds output spike_count_o (16 bit), cleared on reset and on entry to FIRE.
  - Increments on each spike handshake; saturates at 16'hFFFF.
  - Value is held after DONE until the next FIRE entry.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: NUM_NEURONS=4, RESET_POTENTIAL=-2; pulse rst_i -> all pot=-2, axon_ready_o=1, spike_valid_o=0, busy_o=0.
- Integrate: event idx=1, type=2, syn_row=4'b0101, datapath adds weight3=+5 when enabled -> pot={3,-2,3,-2}; syn_addr_o=1 on the accept cycle; axon_ready_o high again 6 cycles after accept.
- Fire with backpressure: pot={10,0,12,0}, threshold 8, reset 0 -> spikes idx 0 then 2. With spike_ready_i low for 3 cycles on idx 0: spike_idx_o held at 0 and pot[0] unchanged until accept. done_o pulses once; pot all 0.
- Picture during integrate: picture_done_i at cycle 2 of INTEG -> event completes, then FIRE begins. An axon_valid_i held high during this time is not accepted until after done_o.
- Simultaneous requests: axon_valid_i and picture_done_i in the same IDLE cycle -> event accepted and integrated, then fire sweep, then done_o.
- Mid-sweep reset and counter: rst_i during FIRE -> IDLE, no done_o. With SPIKE_COUNT_EN defined and 3 spikes accepted, spike_count_o=3; it is cleared at the next FIRE entry.
